uart_tx_engine: RTL and testbench

//  Serial UART transmitter at the far end of the FSM's tx / tx_status handshake; it sends matrix bytes back to the host PC.
//  On a rising edge of tx it captures data_in and shifts out one 8-bit frame, LSB first, on txd.
//  The baud rate is chosen by b_sel. tx_status is high for the whole transmission.
//  A one-deep holding register accepts a second byte while a frame is still on the line.

---
 rtl/uart_tx_engine.sv | 93 +++++++++
 tb/tb_uart_tx_engine.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: 8-bit UART transmitter with selectable baud, optional parity and a one-deep holding register
module uart_tx_engine #(
  parameter int DIV_B0     = 325,
  parameter int DIV_B1     = 651,
  parameter int DIV_B2     = 1302,
  parameter int DIV_B3     = 3906,
  parameter int OVS        = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] b_sel,
  input  logic       tx,
  input  logic [7:0] data_in,
  output logic       txd,
  output logic       tx_status,
  output logic       frame_done,
  output logic       overrun
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [15:0] P0 = 16'(DIV_B0 * OVS - 1);
  localparam logic [15:0] P1 = 16'(DIV_B1 * OVS - 1);
  localparam logic [15:0] P2 = 16'(DIV_B2 * OVS - 1);
  localparam logic [15:0] P3 = 16'(DIV_B3 * OVS - 1);
  state_t      r_state, w_state_nx;
  logic [15:0] r_timer, r_per, w_new_per;
  logic [2:0]  r_cnt;
  logic [7:0]  r_shift, r_hold, w_src;
  logic        r_hold_full, r_par, r_tx_q, r_overrun;
  logic        w_busy, w_req, w_tick, w_end, w_new_frame, w_take_hold, w_start, w_to_hold, w_drop;
  assign w_busy      = r_state != IDLE;
  assign w_req       = tx & ~r_tx_q;
  assign w_tick      = r_timer == '0;
  assign w_end       = r_state == STOP && w_tick && r_cnt == 3'(STOP_BITS - 1);
  assign w_new_frame = w_req && (!w_busy || (w_end && !r_hold_full));
  assign w_take_hold = w_end && r_hold_full;
  assign w_start     = w_new_frame || w_take_hold;
  assign w_to_hold   = w_req && w_busy && !w_new_frame && (!r_hold_full || w_end);
  assign w_drop      = w_req && w_busy && r_hold_full && !w_end;
  assign w_src       = w_take_hold ? r_hold : data_in;
  assign w_new_per   = b_sel == 2'd0 ? P0 : b_sel == 2'd1 ? P1 : b_sel == 2'd2 ? P2 : P3;
  assign txd         = r_state == START ? 1'b0 : r_state == DATA ? r_shift[0] : r_state == PARITY ? r_par : 1'b1;
  assign tx_status   = w_busy;
  assign frame_done  = w_end;
  assign overrun     = r_overrun;
  // state register
  always_ff @(posedge clk) begin
    r_state <= rst ? IDLE : w_state_nx;
  end
  // next state: each bit state advances when the bit timer expires
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    w_state_nx = w_start ? START : IDLE;
      START:   w_state_nx = w_tick ? DATA : START;
      DATA:    w_state_nx = (w_tick && r_cnt == 3'd7) ? ((PARITY_EN != 0) ? PARITY : STOP) : DATA;
      PARITY:  w_state_nx = w_tick ? STOP : PARITY;
      STOP:    w_state_nx = w_end ? (w_start ? START : IDLE) : STOP;
      default: w_state_nx = IDLE;
    endcase
  end
  // datapath: bit timer, bit counter, shifter, holding register, edge detector and overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer     <= '0;
      r_per       <= P0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_par       <= 1'b0;
      r_tx_q      <= 1'b1;
      r_overrun   <= 1'b0;
    end else begin
      r_tx_q      <= tx;
      r_overrun   <= r_overrun | w_drop;
      r_hold_full <= w_to_hold || (r_hold_full && !w_take_hold);
      if (w_to_hold) r_hold <= data_in;
      r_cnt <= (w_start || w_state_nx != r_state) ? 3'd0 : w_tick ? r_cnt + 3'd1 : r_cnt;
      if (w_start) begin
        r_per   <= w_new_per;
        r_timer <= w_new_per;
        r_shift <= w_src;
        r_par   <= ^w_src ^ 1'(PARITY_ODD);
      end else if (w_busy) begin
        r_timer <= w_end ? '0 : w_tick ? r_per : r_timer - 16'd1;
        if (r_state == DATA && w_tick) r_shift <= r_shift >> 1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: scoreboard bench; stimulus queues expected frames, a monitor decodes txd cycle by cycle
module tb_uart_tx_engine;
  logic clk = 0, rst = 1;
  logic [1:0] b_sel = 0;
  logic tx_a = 0, tx_p = 0;
  logic [7:0] data_in = 0;
  logic txd_a, st_a, fd_a, ov_a, txd_p, st_p, fd_p, ov_p;
  logic m_txd, m_stat, m_done;
  bit sel = 0, mon_en = 1, mon_busy = 0;
  int checks = 0, errors = 0, cyc = 0, last_end = -100;
  typedef struct {logic [10:0] bits; int n; int per; bit b2b;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  assign m_txd  = sel ? txd_p : txd_a;
  assign m_stat = sel ? st_p : st_a;
  assign m_done = sel ? fd_p : fd_a;

  // bit periods: b_sel 0..3 -> 4, 6, 8, 10 clocks
  uart_tx_engine #(.DIV_B0(2), .DIV_B1(3), .DIV_B2(4), .DIV_B3(5), .OVS(2)) dut (
    .clk(clk), .rst(rst), .b_sel(b_sel), .tx(tx_a), .data_in(data_in),
    .txd(txd_a), .tx_status(st_a), .frame_done(fd_a), .overrun(ov_a));
  uart_tx_engine #(.DIV_B0(2), .DIV_B1(3), .DIV_B2(4), .DIV_B3(5), .OVS(2),
                   .PARITY_EN(1), .PARITY_ODD(1)) dut_p (
    .clk(clk), .rst(rst), .b_sel(b_sel), .tx(tx_p), .data_in(data_in),
    .txd(txd_p), .tx_status(st_p), .frame_done(fd_p), .overrun(ov_p));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [10:0] bits, input int n, input int per, input bit b2b);
    exp_t e;
    e.bits = bits; e.n = n; e.per = per; e.b2b = b2b;
    q.push_back(e);
  endtask

  task automatic send(input logic [7:0] d);
    @(posedge clk); #1;
    data_in = d;
    if (sel) tx_p = 1; else tx_a = 1;
    @(posedge clk); #1;
    tx_a = 0; tx_p = 0;
  endtask

  task automatic wait_idle(input int max);
    bit done = 0;
    for (int i = 0; i < max && !done; i++) begin
      @(posedge clk); #2;
      done = q.size() == 0 && !mon_busy && !m_stat;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL idle_timeout: pending=%0d tx_status=%b after %0d cycles", q.size(), m_stat, max);
    end
  endtask

  // monitor: on each start bit, pop the expected frame and compare every cycle of it
  initial begin : mon
    exp_t e;
    bit pt = 1, bad, dbad, sbad;
    logic got;
    forever begin
      @(negedge clk); cyc++;
      if (mon_en && pt === 1'b1 && m_txd === 1'b0) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame: start bit at cycle %0d with none required", cyc);
        end else begin
          e = q.pop_front();
          mon_busy = 1; dbad = 0; sbad = 0;
          if (e.b2b) chk("no_gap", cyc - last_end, 1);
          for (int b = 0; b < e.n; b++) begin
            bad = 0; got = e.bits[b];
            for (int c = 0; c < e.per; c++) begin
              if (b != 0 || c != 0) begin @(negedge clk); cyc++; end
              if (m_txd !== e.bits[b]) begin bad = 1; got = m_txd; end
              if (m_done !== (b == e.n - 1 && c == e.per - 1)) dbad = 1;
              if (m_stat !== 1'b1) sbad = 1;
            end
            checks++;
            if (bad) begin
              errors++;
              $display("FAIL frame_bit%0d: txd=%b required=%b for %0d clocks", b, got, e.bits[b], e.per);
            end
          end
          chk("frame_done_pulse", dbad, 0);
          chk("tx_status_high", sbad, 0);
          last_end = cyc;
          mon_busy = 0;
        end
      end
      pt = m_txd;
    end
  end

  function automatic logic [10:0] frame(input logic [7:0] d);
    return {2'b11, d, 1'b0};
  endfunction

  initial begin
    tx_a = 1; tx_p = 1;
    repeat (3) @(posedge clk); #1;
    chk("rst_txd", txd_a, 1); chk("rst_status", st_a, 0);
    chk("rst_done", fd_a, 0); chk("rst_overrun", ov_a, 0);
    chk("rst_txd_p", txd_p, 1); chk("rst_status_p", st_p, 0);
    rst = 0;
    repeat (10) @(posedge clk); #1;
    chk("held_tx_no_start", st_a, 0);
    chk("held_tx_no_start_p", st_p, 0);
    tx_a = 0; tx_p = 0;
    // T1: A5 at 6 clocks/bit; b_sel change mid-frame must not alter timing
    b_sel = 1;
    expect_frame(11'b11_1010_0101_0, 10, 6, 0);
    send(8'hA5);
    repeat (10) @(posedge clk); #1;
    b_sel = 3;
    wait_idle(200);
    chk("t1_idle_txd", txd_a, 1);
    // T2: level held high sends exactly one frame
    b_sel = 0;
    expect_frame(frame(8'h00), 10, 4, 0);
    @(posedge clk); #1; data_in = 8'h00; tx_a = 1;
    repeat (200) @(posedge clk); #1;
    chk("t2_no_retrigger", st_a, 0);
    tx_a = 0;
    wait_idle(50);
    // T3: second byte while busy goes back to back
    b_sel = 3;
    expect_frame(frame(8'h3C), 10, 10, 0);
    expect_frame(frame(8'h81), 10, 10, 1);
    send(8'h3C);
    repeat (25) @(posedge clk);
    send(8'h81);
    wait_idle(400);
    chk("t3_overrun", ov_a, 0);
    // T4: third byte with holding register full is dropped
    b_sel = 2;
    expect_frame(frame(8'h55), 10, 8, 0);
    expect_frame(frame(8'h0F), 10, 8, 1);
    send(8'h55);
    repeat (20) @(posedge clk);
    send(8'h0F);
    repeat (20) @(posedge clk); #1;
    chk("t4_overrun_before", ov_a, 0);
    send(8'hF0);
    wait_idle(400);
    chk("t4_overrun", ov_a, 1);
    // T5: odd parity on 07 -> parity bit 0, 11-bit frame
    sel = 1; b_sel = 0;
    expect_frame({1'b1, 1'b0, 8'h07, 1'b0}, 11, 4, 0);
    send(8'h07);
    wait_idle(200);
    chk("t5_overrun_p", ov_p, 0);
    sel = 0;
    // T6: reset during D3 aborts the frame, next frame is clean
    mon_en = 0;
    send(8'h00);
    repeat (18) @(posedge clk); #1;
    chk("t6_d3_txd", txd_a, 0);
    chk("t6_d3_status", st_a, 1);
    rst = 1;
    @(posedge clk); #1;
    chk("t6_abort_txd", txd_a, 1);
    chk("t6_abort_status", st_a, 0);
    chk("t6_overrun_cleared", ov_a, 0);
    rst = 0;
    repeat (3) @(posedge clk); #1;
    mon_en = 1;
    expect_frame(frame(8'h5A), 10, 4, 0);
    send(8'h5A);
    wait_idle(200);
    chk("t6_idle_txd", txd_a, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
